// File: rtl/lector_destinos_if.sv
//------------------------------------------------------------------------------
// Module   : lector_destinos_if
// Brief    : Destination-FIFO read side plus merged output stream bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface lector_destinos_if #(
    parameter int BW    = 6,
    parameter int CNT_W = 5
);
    logic             init;
    logic             D0_empty;
    logic             D1_empty;
    logic             D0_error_output;
    logic             D1_error_output;
    logic [BW-1:0]    D0_data_out;
    logic [BW-1:0]    D1_data_out;
    logic             D0_rd;
    logic             D1_rd;
    logic             out_ready;
    logic             out_valid;
    logic [BW-1:0]    out_data;
    logic             out_dest;
    logic [CNT_W-1:0] count_D0;
    logic [CNT_W-1:0] count_D1;
    logic             error_seen;
    logic             idle;

    // master: the reader (pops the FIFOs, sources the output stream)
    modport master (
        input  init, D0_empty, D1_empty, D0_error_output, D1_error_output,
        input  D0_data_out, D1_data_out, out_ready,
        output D0_rd, D1_rd, out_valid, out_data, out_dest,
        output count_D0, count_D1, error_seen, idle
    );

    modport slave (
        output init, D0_empty, D1_empty, D0_error_output, D1_error_output,
        output D0_data_out, D1_data_out, out_ready,
        input  D0_rd, D1_rd, out_valid, out_data, out_dest,
        input  count_D0, count_D1, error_seen, idle
    );
endinterface

`default_nettype wire

// File: rtl/lector_destinos.sv
//------------------------------------------------------------------------------
// Module   : lector_destinos
// Brief    : Round-robin drain of destination FIFOs D0/D1 into one
//            flow-controlled stream with per-destination delivery counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lector_destinos #(
    parameter int BW    = 6,
    parameter int CNT_W = 5
) (
    input  wire logic         clk,
    input  wire logic         reset_L,
    lector_destinos_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t                r_state;
    logic                  r_rr_next;
    logic                  r_inflight;
    logic                  r_inflight_dest;
    logic [1:0]            r_count;
    logic [1:0][BW-1:0]    r_buf_data;
    logic [1:0]            r_buf_dest;
    logic [CNT_W-1:0]      r_cnt0;
    logic [CNT_W-1:0]      r_cnt1;
    logic                  r_error_seen;
    logic                  r_idle;

    logic                  w_err;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_xfer;
    logic [2:0]            w_occ;
    logic                  w_rd0;
    logic                  w_rd1;
    logic [BW-1:0]         w_cap_data;

    assign w_err      = bus.D0_error_output | bus.D1_error_output;
    assign w_elig0    = !bus.D0_empty && !bus.D0_error_output;
    assign w_elig1    = !bus.D1_empty && !bus.D1_error_output;
    assign w_xfer     = (r_count != 2'd0) && bus.out_ready;
    assign w_cap_data = r_inflight_dest ? bus.D1_data_out : bus.D0_data_out;

    // Occupancy at the end of this cycle, so a head leaving now frees its slot
    // for a new pop and the stream sustains one word per cycle.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_xfer};

    // rd is decoded from registered state and the live empty flags so a pop is
    // never issued toward a FIFO that has just been drained.
    always_comb begin
        w_rd0 = 1'b0;
        w_rd1 = 1'b0;
        if (r_state == S_READ && w_occ < 3'd2) begin
            if (w_elig0 && w_elig1) begin
                w_rd0 = !r_rr_next;
                w_rd1 = r_rr_next;
            end else if (w_elig0) begin
                w_rd0 = 1'b1;
            end else if (w_elig1) begin
                w_rd1 = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state         <= S_IDLE;
            r_rr_next       <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_dest <= 1'b0;
            r_count         <= 2'd0;
            r_buf_data      <= '0;
            r_buf_dest      <= '0;
            r_cnt0          <= '0;
            r_cnt1          <= '0;
            r_error_seen    <= 1'b0;
            r_idle          <= 1'b0;
        end else begin
            if (w_err) begin
                r_state <= S_HALT;
            end else begin
                case (r_state)
                    S_IDLE: if (!bus.D0_empty || !bus.D1_empty) r_state <= S_READ;
                    S_READ: if (bus.D0_empty && bus.D1_empty && !r_inflight &&
                                r_count == 2'd0) r_state <= S_IDLE;
                    S_HALT: if (bus.init) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end

            if (w_rd0)      r_rr_next <= 1'b1;
            else if (w_rd1) r_rr_next <= 1'b0;

            r_inflight <= w_rd0 | w_rd1;
            if (w_rd0 | w_rd1) r_inflight_dest <= w_rd1;

            // Two-entry buffer, entry 0 is the head.
            case ({w_xfer, r_inflight})
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_buf_data[0] <= r_buf_data[1];
                        r_buf_dest[0] <= r_buf_dest[1];
                        r_buf_data[1] <= w_cap_data;
                        r_buf_dest[1] <= r_inflight_dest;
                    end else begin
                        r_buf_data[0] <= w_cap_data;
                        r_buf_dest[0] <= r_inflight_dest;
                    end
                end
                2'b10: begin
                    r_buf_data[0] <= r_buf_data[1];
                    r_buf_dest[0] <= r_buf_dest[1];
                    r_count       <= r_count - 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd0) begin
                        r_buf_data[0] <= w_cap_data;
                        r_buf_dest[0] <= r_inflight_dest;
                    end else begin
                        r_buf_data[1] <= w_cap_data;
                        r_buf_dest[1] <= r_inflight_dest;
                    end
                    r_count <= r_count + 2'd1;
                end
                default: ;
            endcase

            if (bus.init) begin
                r_cnt0 <= '0;
                r_cnt1 <= '0;
            end else if (w_xfer) begin
                if (!r_buf_dest[0] && r_cnt0 != c_cnt_max) r_cnt0 <= r_cnt0 + 1'b1;
                if (r_buf_dest[0] && r_cnt1 != c_cnt_max)  r_cnt1 <= r_cnt1 + 1'b1;
            end

            if (w_err)         r_error_seen <= 1'b1;
            else if (bus.init) r_error_seen <= 1'b0;

            r_idle <= (r_state == S_IDLE) && bus.D0_empty && bus.D1_empty &&
                      (r_count == 2'd0) && !r_inflight;
        end
    end

    assign bus.D0_rd      = w_rd0;
    assign bus.D1_rd      = w_rd1;
    assign bus.out_valid  = (r_count != 2'd0);
    assign bus.out_data   = r_buf_data[0];
    assign bus.out_dest   = r_buf_dest[0];
    assign bus.count_D0   = r_cnt0;
    assign bus.count_D1   = r_cnt1;
    assign bus.error_seen = r_error_seen;
    assign bus.idle       = r_idle;

endmodule

`default_nettype wire
